// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared constants, enums and burst-legality helper for the AXI3 slave blocks
package axi3_pkg;

  localparam int DATAWIDTH = 32;
  localparam int SIZE      = 3;
  localparam int MEMDEPTH  = 4096;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } wr_state_t;

  // Reserved burst type, or WRAP with a beat count that is not 2/4/8/16.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [31:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    return (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi3_burst_addr.sv
// rtl/axi3_burst_addr.sv - combinational AXI3 next-beat address for FIXED/INCR/WRAP bursts
// Illegal WRAP and reserved bursts advance as INCR and raise wrap_illegal.
module axi3_burst_addr #(
  parameter int AW = 32,
  parameter int LW = 4,
  parameter int SW = 3
) (
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] len,
  input  logic [SW-1:0] size,
  input  logic [SW-2:0] burst,
  output logic [AW-1:0] next_addr,
  output logic          wrap_illegal
);
  import axi3_pkg::*;

  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] span;
  logic [AW-1:0] low;

  always_comb begin
    beat_bytes   = AW'(1) << size;
    span         = (AW'(len) + AW'(1)) << size;
    low          = addr & ~(span - AW'(1));
    wrap_illegal = burst_illegal(2'(burst), 32'(len));
    next_addr    = (addr & ~(beat_bytes - AW'(1))) + beat_bytes;
    if (burst == FIXED) begin
      next_addr = addr;
    end else if ((burst == WRAP) && !wrap_illegal) begin
      // span is a power of two here, so the modulo is a mask
      next_addr = low + ((addr + beat_bytes - low) & (span - AW'(1)));
    end
  end

endmodule

// File: rtl/axi3_slave_write.sv
// rtl/axi3_slave_write.sv - AXI3 slave write engine: AW/W/B handshakes into a byte memory
// Define AXI_ADDR_CHECK_EN to drop out-of-range lanes with SLVERR instead of wrapping addresses.
module axi3_slave_write #(
  parameter int DATAWIDTH = axi3_pkg::DATAWIDTH,
  parameter int SIZE      = axi3_pkg::SIZE,
  parameter int MEMDEPTH  = axi3_pkg::MEMDEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATAWIDTH-1:0]          AWaddr,
  input  logic [DATAWIDTH/8-1:0]        AWlen,
  input  logic [DATAWIDTH/8-1:0]        AWid,
  input  logic [SIZE-1:0]               AWsize,
  input  logic [SIZE-2:0]               AWburst,
  input  logic                          AWvalid,
  output logic                          AWready,
  input  logic [DATAWIDTH-1:0]          WData,
  input  logic [DATAWIDTH/8-1:0]        WStrb,
  input  logic                          WLast,
  input  logic                          WValid,
  output logic                          WReady,
  output logic [DATAWIDTH/8-1:0]        Bid,
  output logic [1:0]                    Bresp,
  output logic                          BValid,
  input  logic                          BReady,
  output logic [MEMDEPTH-1:0][7:0]      write_memory
);
  import axi3_pkg::*;

  localparam int LANES     = DATAWIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int ADDR_BITS = $clog2(MEMDEPTH);

  wr_state_t             state_q, state_d;
  logic [DATAWIDTH-1:0]  addr_q, addr_d;
  logic [LANES-1:0]      len_q, len_d;
  logic [LANES-1:0]      id_q, id_d;
  logic [LANES-1:0]      cnt_q, cnt_d;
  logic [SIZE-1:0]       size_q, size_d;
  logic [SIZE-2:0]       burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  size_bad_q, size_bad_d;

  logic [DATAWIDTH-1:0]  ba_addr;
  logic [LANES-1:0]      ba_len;
  logic [SIZE-1:0]       ba_size;
  logic [SIZE-2:0]       ba_burst;
  logic [DATAWIDTH-1:0]  next_addr;
  logic                  burst_bad;

  logic                  beat_fire;
  logic                  last_beat;
  logic                  range_err;
  logic [LANES-1:0]      lane_we;
  logic [LANES-1:0][ADDR_BITS-1:0] lane_idx;
  logic [MEMDEPTH-1:0][7:0] mem_q;
`ifdef AXI_ADDR_CHECK_EN
  logic [DATAWIDTH-1:0]  lane_addr;
`endif

  // In IDLE the calculator looks at the incoming AW so legality is known at the handshake.
  always_comb begin
    if (state_q == S_IDLE) begin
      ba_addr  = AWaddr;
      ba_len   = AWlen;
      ba_size  = AWsize;
      ba_burst = AWburst;
    end else begin
      ba_addr  = addr_q;
      ba_len   = len_q;
      ba_size  = size_q;
      ba_burst = burst_q;
    end
  end

  axi3_burst_addr #(
    .AW (DATAWIDTH),
    .LW (LANES),
    .SW (SIZE)
  ) u_burst_addr (
    .addr         (ba_addr),
    .len          (ba_len),
    .size         (ba_size),
    .burst        (ba_burst),
    .next_addr    (next_addr),
    .wrap_illegal (burst_bad)
  );

  assign beat_fire = (state_q == S_DATA) && WValid;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    lane_we   = '0;
    lane_idx  = '0;
    range_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i] = (addr_q[ADDR_BITS-1:0] & ~ADDR_BITS'(LANES - 1)) + ADDR_BITS'(i);
      lane_we[i]  = beat_fire && WStrb[i] && !size_bad_q;
`ifdef AXI_ADDR_CHECK_EN
      lane_addr = (addr_q & ~DATAWIDTH'(LANES - 1)) + DATAWIDTH'(i);
      if (lane_addr > DATAWIDTH'(MEMDEPTH - 1)) begin
        if (lane_we[i]) begin
          range_err = 1'b1;
        end
        lane_we[i] = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    size_bad_d = size_bad_q;
    AWready    = 1'b0;
    WReady     = 1'b0;
    BValid     = 1'b0;
    Bid        = '0;
    Bresp      = OKAY;
    unique case (state_q)
      S_IDLE: begin
        AWready = 1'b1;
        if (AWvalid) begin
          addr_d     = AWaddr;
          len_d      = AWlen;
          id_d       = AWid;
          size_d     = AWsize;
          burst_d    = AWburst;
          cnt_d      = '0;
          size_bad_d = AWsize > SIZE'(LANE_BITS);
          err_d      = burst_bad || (AWsize > SIZE'(LANE_BITS));
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        WReady = 1'b1;
        if (WValid) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + LANES'(1);
          // The counter ends the burst; a misplaced WLast only taints the response.
          if ((WLast != last_beat) || range_err) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        BValid = 1'b1;
        Bid    = id_q;
        Bresp  = err_q ? SLVERR : OKAY;
        if (BReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      size_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      size_bad_q <= size_bad_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) begin
          mem_q[lane_idx[i]] <= WData[8*i +: 8];
        end
      end
    end
  end

  assign write_memory = mem_q;

endmodule

// File: doc/axi3_slave_write.md
# axi3_slave_write

Slave-side AXI3 write engine that sits directly downstream of the master write FSM. It consumes the write address (AW) and write data (W) channels, computes per-beat addresses for FIXED/INCR/WRAP bursts, and commits strobed bytes into a 4096-byte memory. It then returns the write response (B) with the burst's ID. It is the target that the master's MWRITE_* address/data sequencing handshakes against.

## Interface
Parameters:
- DATAWIDTH, 32, data bus width in bits; byte lanes = DATAWIDTH/8
- SIZE, 3, width of AWsize; AWburst is SIZE-1 bits
- MEMDEPTH, 4096, memory size in bytes

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- AWaddr  in  DATAWIDTH  burst start byte address
- AWlen  in  DATAWIDTH/8  beats minus 1 (0..15)
- AWid  in  DATAWIDTH/8  transaction ID
- AWsize  in  SIZE  bytes per beat = 1<<AWsize
- AWburst  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWvalid / AWready  in / out  1  AW handshake
- WData  in  DATAWIDTH  beat data
- WStrb  in  DATAWIDTH/8  byte-lane enables
- WLast  in  1  final-beat marker from master
- WValid / WReady  in / out  1  W handshake
- Bid  out  DATAWIDTH/8  echoed AWid
- Bresp  out  2  00 OKAY, 10 SLVERR
- BValid / BReady  out / in  1  B handshake
- write_memory  out  [MEMDEPTH-1:0][7:0]  byte memory contents

## Operation
- FSM states:
  - S_IDLE: AWready=1. AWvalid&AWready latches addr, len, id, size, burst, clears the beat counter and error flag, and moves to S_DATA.
  - S_DATA: WReady=1. Each WValid&WReady writes a beat and advances the address and counter. When counter==len, the FSM moves to S_RESP.
  - S_RESP: BValid=1 with Bid and Bresp. BValid&BReady returns the FSM to S_IDLE.
- No write-data-before-address: WReady stays 0 outside S_DATA, so W beats presented early are held by the master, not dropped.
- Beat write: aligned base = addr & ~(DATAWIDTH/8-1). For each lane i with WStrb[i]=1, write mem[base+i] = WData[8i+7:8i].
- Address update:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~((1<<size)-1)) + (1<<size). The first beat may be unaligned; later beats are aligned.
  - WRAP: boundary B = (len+1)<<size and low = addr & ~(B-1). next = low + ((addr + (1<<size) - low) mod B).
- WRAP legality: WRAP with len not in {1,3,7,15}, or reserved burst 11, is executed as INCR and sets SLVERR.
- Size legality: AWsize > log2(DATAWIDTH/8) sets SLVERR and suppresses all memory writes for the burst.
- Beat counter is authoritative. If WLast is asserted when counter!=len, or deasserted when counter==len, SLVERR is set; the burst still completes on counter==len.
- Memory is addressed with the low 12 bits, except as described under Configuration.

## Timing
- Reset values: FSM=S_IDLE, AWready=1, WReady=0, BValid=0, Bid=0, Bresp=00, write_memory all 0. Reset takes effect immediately when rst is asserted.
- AW handshake at edge N: WReady=1 from cycle N+1.
- Beat handshake at edge k: memory updates at edge k, visible the cycle after.
- Last-beat handshake at edge M: WReady=0 and BValid=1 from cycle M+1.
- B handshake at edge P: AWready=1 from cycle P+1.
- Best-case burst takes len+3 cycles; there is no overlap between consecutive bursts.
- BValid, Bid and Bresp are held stable until BReady; AWvalid during S_DATA/S_RESP is ignored.
- Reset mid-burst aborts the burst with no B response; memory returns to 0.

## Configuration
- AXI_ADDR_CHECK_EN defined: any beat whose base+lane exceeds MEMDEPTH-1 is not written, and Bresp=SLVERR. Other beats are written normally.
- AXI_ADDR_CHECK_EN undefined: addresses are truncated to log2(MEMDEPTH) bits (wrap to 0), and no SLVERR is raised for range.

## Structure
- axi3_pkg holds:
  - the DATAWIDTH, SIZE and MEMDEPTH constants
  - typedef enum burst_t {FIXED, INCR, WRAP}
  - typedef enum resp_t {OKAY=2'b00, SLVERR=2'b10}
  - the slave write state enum
- Sub-module axi3_burst_addr: combinational next-address calculation from (addr, len, size, burst), plus wrap/illegal flags. It is reusable by the future read-slave block.

## Test plan
- INCR: AWaddr=0x100, len=3, size=2, WStrb=F, data 0x11111111..0x44444444 -> mem[0x100..0x10F] filled; Bresp=00; Bid=AWid; BValid the cycle after beat 4.
- WRAP: AWaddr=0x108, len=3, size=2 -> beats land at 0x108, 0x10C, 0x100, 0x104; Bresp=00.
- FIXED: AWaddr=0x20, len=2, WStrb=1, data 0xAA/0xBB/0xCC -> mem[0x20]=0xCC, mem[0x21..0x23] unchanged.
- Backpressure/protocol: BReady low 5 cycles -> BValid, Bid and Bresp held and AWready=0; WLast on beat 2 of len=3 -> Bresp=10, 4 beats still consumed.
- Address check: AWaddr=0xFFC, len=1, size=2:
  - with AXI_ADDR_CHECK_EN -> Bresp=10, mem[0x000..0x003] untouched.
  - without -> beat 2 writes mem[0x000..0x003], Bresp=00.
- Reset after 2 of 4 beats -> WReady=0, BValid=0, AWready=1, memory all 0; a following clean burst completes OKAY.
